// File: rtl/stream_pkg.sv
// Shared definitions for the stream demultiplexer.
// Contents: output count, select width, default payload width,
//           held-slot struct and the select range check.
package stream_pkg;

    localparam int unsigned NUM_OUT = 5;
    localparam int unsigned SEL_W   = 3;
    localparam int unsigned DATA_W  = 32;

    // Contents of the single holding slot.
    typedef struct packed {
        logic              valid;
        logic [SEL_W-1:0]  sel;
        logic [DATA_W-1:0] data;
    } slot_t;

    // A select addresses a real output only when it is below NUM_OUT.
    function automatic logic is_valid_sel(input logic [SEL_W-1:0] sel);
        return sel < SEL_W'(NUM_OUT);
    endfunction

endpackage

// File: rtl/stream_demux_5_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports: clk, clr (sync clear, wins over inc), inc (count one),
//        cnt (current value, sticks at all-ones).
module sat_counter #(
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/stream_demux_5.sv
// One-stage valid/ready demultiplexer: routes each input beat to one of five
// outputs chosen by the 3-bit select travelling with the beat.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid/in_ready     input handshake (in_ready is combinational)
//   in_data, in_sel       beat payload and destination (0..4 valid, 5..7 dropped)
//   out_valid[4:0]        one-hot valid for the held beat
//   out_ready[4:0]        per-consumer ready; only the selected bit matters
//   out_data              shared payload of the held beat
//   drop_err              one-cycle pulse after an invalid-select beat is discarded
// Option STREAM_DEMUX_STATS_EN adds xfer_cnt (per-output drained beats) and
// drop_cnt (discarded beats), both saturating, cleared by rst.
module stream_demux_5
    import stream_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_W
`ifdef STREAM_DEMUX_STATS_EN
    ,parameter int unsigned CNT_WIDTH = 16
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]      in_sel,
    output logic [NUM_OUT-1:0]    out_valid,
    input  logic [NUM_OUT-1:0]    out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  drop_err
`ifdef STREAM_DEMUX_STATS_EN
    ,output logic [NUM_OUT*CNT_WIDTH-1:0] xfer_cnt,
    output logic [CNT_WIDTH-1:0]          drop_cnt
`endif
);

    logic                  hold_v;
    logic [SEL_W-1:0]      hold_sel;
    logic [DATA_WIDTH-1:0] hold_data;

    logic drain;
    logic accept;
    logic sel_ok;

    // Only the consumer addressed by the held beat can release the slot.
    assign drain    = hold_v & out_ready[hold_sel];
    assign in_ready = ~hold_v | drain;
    assign accept   = in_valid & in_ready;
    assign sel_ok   = is_valid_sel(in_sel);

    assign out_valid = hold_v ? (NUM_OUT'(1) << hold_sel) : '0;
    assign out_data  = hold_data;

    // Slot update: a valid-select accept reloads, otherwise a drain empties.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_v    <= 1'b0;
            hold_sel  <= '0;
            hold_data <= '0;
            drop_err  <= 1'b0;
        end else begin
            drop_err <= accept & ~sel_ok;
            if (accept && sel_ok) begin
                hold_v    <= 1'b1;
                hold_sel  <= in_sel;
                hold_data <= in_data;
            end else if (drain) begin
                hold_v <= 1'b0;
            end
        end
    end

`ifdef STREAM_DEMUX_STATS_EN
    // Per-output drained-beat counters.
    for (genvar k = 0; k < NUM_OUT; k++) begin : g_xfer
        sat_counter #(
            .CNT_WIDTH (CNT_WIDTH)
        ) u_xfer_cnt (
            .clk (clk),
            .clr (rst),
            .inc (drain && (hold_sel == SEL_W'(k))),
            .cnt (xfer_cnt[k*CNT_WIDTH +: CNT_WIDTH])
        );
    end

    // Discarded invalid-select beats.
    sat_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_drop_cnt (
        .clk (clk),
        .clr (rst),
        .inc (accept & ~sel_ok),
        .cnt (drop_cnt)
    );
`endif

endmodule

// File: tb/tb_stream_demux_5.sv
// Self-checking bench for stream_demux_5: directed scenarios followed by
// random traffic, compared against a queue-based model of the one-slot buffer.
module tb_stream_demux_5;

    localparam int unsigned DW   = 32;
    localparam int unsigned CW   = 2;
    localparam int unsigned CMAX = (1 << CW) - 1;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [2:0]    in_sel;
    logic [4:0]    out_valid;
    logic [4:0]    out_ready;
    logic [DW-1:0] out_data;
    logic          drop_err;
`ifdef STREAM_DEMUX_STATS_EN
    logic [5*CW-1:0] xfer_cnt;
    logic [CW-1:0]   drop_cnt;
`endif

    stream_demux_5 #(
        .DATA_WIDTH (DW)
`ifdef STREAM_DEMUX_STATS_EN
        ,.CNT_WIDTH (CW)
`endif
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .drop_err  (drop_err)
`ifdef STREAM_DEMUX_STATS_EN
        ,.xfer_cnt (xfer_cnt),
        .drop_cnt  (drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]    sel;
        logic [DW-1:0] data;
    } beat_t;

    // Model: a buffer of at most one beat, plus expected pulse and tallies.
    beat_t       slot_q[$];
    logic        exp_drop;
    int unsigned xfer_m[5];
    int unsigned drop_m;
    bit          model_ok;

    int n_checks;
    int n_err;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: apply inputs, compare current outputs, advance model.
    task automatic cycle(input logic r, input logic v, input logic [2:0] s,
                         input logic [DW-1:0] d, input logic [4:0] o);
        logic        drn;
        logic        rdy;
        logic        acc;
        logic [4:0]  ev;
        rst       = r;
        in_valid  = v;
        in_sel    = s;
        in_data   = d;
        out_ready = o;
        #1;
        drn = (slot_q.size() != 0) && o[slot_q[0].sel];
        rdy = (slot_q.size() == 0) || drn;
        acc = v && rdy;
        if (model_ok) begin
            ev = (slot_q.size() != 0) ? 5'(1 << slot_q[0].sel) : 5'd0;
            check("in_ready", 64'(in_ready), 64'(rdy));
            check("out_valid", 64'(out_valid), 64'(ev));
            if (slot_q.size() != 0)
                check("out_data", 64'(out_data), 64'(slot_q[0].data));
            check("drop_err", 64'(drop_err), 64'(exp_drop));
`ifdef STREAM_DEMUX_STATS_EN
            for (int k = 0; k < 5; k++)
                check($sformatf("xfer_cnt%0d", k), 64'(xfer_cnt[k*CW +: CW]), 64'(xfer_m[k]));
            check("drop_cnt", 64'(drop_cnt), 64'(drop_m));
`endif
        end
        if (r) begin
            slot_q.delete();
            exp_drop = 1'b0;
            for (int k = 0; k < 5; k++) xfer_m[k] = 0;
            drop_m   = 0;
            model_ok = 1'b1;
        end else begin
            exp_drop = acc && (s > 3'd4);
            if (drn) begin
                if (xfer_m[slot_q[0].sel] < CMAX) xfer_m[slot_q[0].sel]++;
                void'(slot_q.pop_front());
            end
            if (acc) begin
                if (s <= 3'd4) slot_q.push_back('{sel: s, data: d});
                else if (drop_m < CMAX) drop_m++;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [2:0]    rs;
        logic [DW-1:0] rd;
        n_checks = 0;
        n_err    = 0;
        model_ok = 1'b0;
        exp_drop = 1'b0;
        drop_m   = 0;
        for (int k = 0; k < 5; k++) xfer_m[k] = 0;
        rst = 1'b1; in_valid = 1'b0; in_sel = '0; in_data = '0; out_ready = '0;
        @(negedge clk);

        // Reset held two cycles with a beat offered.
        cycle(1'b1, 1'b1, 3'd1, 32'hFFFF_0000, 5'h1F);
        cycle(1'b1, 1'b1, 3'd1, 32'hFFFF_0000, 5'h1F);
        #1;
        check("reset_out_data", 64'(out_data), 64'd0);

        // Routing to every output back to back.
        for (int i = 0; i < 5; i++)
            cycle(1'b0, 1'b1, 3'(i), DW'(32'hA0 + i), 5'h1F);
        cycle(1'b0, 1'b0, 3'd0, '0, 5'h1F);

        // Backpressure on output 3 with a waiting beat, then drain+load together.
        cycle(1'b0, 1'b1, 3'd3, 32'h1234, 5'h1F);
        for (int i = 0; i < 4; i++)
            cycle(1'b0, 1'b1, 3'd1, 32'h5555, 5'b10111);
        cycle(1'b0, 1'b1, 3'd1, 32'h5555, 5'h1F);
        cycle(1'b0, 1'b0, 3'd0, '0, 5'h1F);

        // Ready on every port except the selected one.
        cycle(1'b0, 1'b1, 3'd2, 32'h22, 5'b11011);
        for (int i = 0; i < 3; i++)
            cycle(1'b0, 1'b1, 3'd4, 32'h44, 5'b11011);
        cycle(1'b0, 1'b0, 3'd0, '0, 5'h1F);
        cycle(1'b0, 1'b0, 3'd0, '0, 5'h1F);

        // Invalid select is swallowed with a single error pulse.
        cycle(1'b0, 1'b1, 3'd6, 32'hDEAD, 5'h1F);
        cycle(1'b0, 1'b0, 3'd0, '0, 5'h1F);
        cycle(1'b0, 1'b0, 3'd0, '0, 5'h1F);

        // Reset while a beat is held.
        cycle(1'b0, 1'b1, 3'd4, 32'hBEEF, 5'h00);
        cycle(1'b1, 1'b0, 3'd0, '0, 5'h00);
        cycle(1'b0, 1'b0, 3'd0, '0, 5'h1F);

        // Five drains on output 0 push its counter into saturation.
        for (int i = 0; i < 5; i++)
            cycle(1'b0, 1'b1, 3'd0, DW'(i), 5'h1F);
        cycle(1'b0, 1'b0, 3'd0, '0, 5'h1F);
        cycle(1'b0, 1'b0, 3'd0, '0, 5'h1F);

        // Random traffic with occasional reset.
        for (int i = 0; i < 400; i++) begin
            rs = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
            rd = $urandom;
            cycle(($urandom_range(0, 63) == 0), 1'($urandom), rs, rd, 5'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
